// File: rtl/gfx_pkg.sv
// Shared graphics definitions: framebuffer geometry, fill FSM states
// and the latched rectangle-fill command.
package gfx_pkg;

    localparam int WIDTH  = 640;
    localparam int HEIGHT = 240;
    localparam int XW     = 10;
    localparam int YW     = 8;
    localparam int AW     = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_DONE
    } fill_state_t;

    typedef struct packed {
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        logic [7:0]    color;
    } fill_cmd_t;

endpackage

// File: rtl/fill_addr_gen.sv
// Rectangle walker: clips the command to the framebuffer and steps
// col/row/addr one byte per advance, flagging the final byte.
import gfx_pkg::*;

module fill_addr_gen (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          adv,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    output logic [AW-1:0] addr,
    output logic          empty,
    output logic          last
);

    logic [XW:0]   room_x;
    logic [YW:0]   room_y;
    logic [XW-1:0] ew_c;
    logic [XW-1:0] ew;
    logic [XW-1:0] col;
    logic [YW-1:0] eh_c;
    logic [YW-1:0] eh;
    logic [YW-1:0] row;
    logic [AW-1:0] rowbase_c;
    logic [AW-1:0] rowbase;
    logic          col_end;

    // room_* is only meaningful when the command is not empty
    always_comb begin
        room_x = (XW+1)'(WIDTH) - {1'b0, x0};
        room_y = (YW+1)'(HEIGHT) - {1'b0, y0};
        ew_c = ({1'b0, w} < room_x) ? w : room_x[XW-1:0];
        eh_c = ({1'b0, h} < room_y) ? h : room_y[YW-1:0];
        rowbase_c = AW'(y0) * AW'(WIDTH) + AW'(x0);
        empty = (x0 >= XW'(WIDTH)) || (y0 >= YW'(HEIGHT))
             || (w == '0) || (h == '0);
        col_end = (col == ew - XW'(1));
        last = col_end && (row == eh - YW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ew      <= '0;
            eh      <= '0;
            col     <= '0;
            row     <= '0;
            rowbase <= '0;
            addr    <= '0;
        end else if (load) begin
            ew      <= ew_c;
            eh      <= eh_c;
            col     <= '0;
            row     <= '0;
            rowbase <= rowbase_c;
            addr    <= rowbase_c;
        end else if (adv && !last) begin
            if (!col_end) begin
                addr <= addr + AW'(1);
                col  <= col + XW'(1);
            end else begin
                rowbase <= rowbase + AW'(WIDTH);
                addr    <= rowbase + AW'(WIDTH);
                col     <= '0;
                row     <= row + YW'(1);
            end
        end
    end

endmodule

// File: rtl/vram_fill_arb.sv
// VRAM port-1 owner: CPU accesses take the port outright, the
// rectangle-fill engine writes one byte on every cycle the CPU leaves free.
import gfx_pkg::*;

module vram_fill_arb (
    input  logic          clk,
    input  logic          rst,
    input  logic          fill_req,
    input  logic [XW-1:0] fill_x0,
    input  logic [YW-1:0] fill_y0,
    input  logic [XW-1:0] fill_w,
    input  logic [YW-1:0] fill_h,
    input  logic [7:0]    fill_color,
    output logic          fill_ack,
    output logic          fill_busy,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic [7:0]    cpu_rdata,
    output logic [AW-1:0] vm_addr,
    output logic [7:0]    vm_wdata,
    output logic          vm_we,
    output logic          vm_re,
    input  logic [7:0]    vm_rdata
);

    fill_state_t   state;
    fill_cmd_t     cmd;
    logic          cpu_sel;
    logic          load;
    logic          adv;
    logic          empty;
    logic          last;
    logic [AW-1:0] gen_addr;

    assign cpu_sel   = cpu_we | cpu_re;
    assign load      = (state == ST_SETUP);
    assign adv       = (state == ST_RUN) && !cpu_sel;
    assign cpu_rdata = vm_rdata;

    fill_addr_gen u_gen (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .adv   (adv),
        .x0    (cmd.x0),
        .y0    (cmd.y0),
        .w     (cmd.w),
        .h     (cmd.h),
        .addr  (gen_addr),
        .empty (empty),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cmd       <= '0;
            fill_ack  <= 1'b0;
            fill_busy <= 1'b0;
        end else begin
            fill_ack <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (fill_req) begin
                        cmd.x0    <= fill_x0;
                        cmd.y0    <= fill_y0;
                        cmd.w     <= fill_w;
                        cmd.h     <= fill_h;
                        cmd.color <= fill_color;
                        fill_busy <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (empty) begin
                        fill_ack <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (adv && last) begin
                        fill_ack <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    fill_busy <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        vm_addr  = '0;
        vm_wdata = '0;
        vm_we    = 1'b0;
        vm_re    = 1'b0;
        if (cpu_sel) begin
            vm_addr  = cpu_addr;
            vm_wdata = cpu_wdata;
            vm_we    = cpu_we;
            vm_re    = cpu_re;
        end else if (state == ST_RUN) begin
            vm_addr  = gen_addr;
            vm_wdata = cmd.color;
            vm_we    = 1'b1;
        end
    end

endmodule

// File: tb/tb_vram_fill_arb.sv
// Directed bench for vram_fill_arb with a behavioural VRAM and a
// log of every fill write and every ack cycle.
import gfx_pkg::*;

module tb_vram_fill_arb;

    logic          clk = 1'b0;
    logic          rst;
    logic          fill_req;
    logic [XW-1:0] fill_x0;
    logic [YW-1:0] fill_y0;
    logic [XW-1:0] fill_w;
    logic [YW-1:0] fill_h;
    logic [7:0]    fill_color;
    logic          fill_ack;
    logic          fill_busy;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_we;
    logic          cpu_re;
    logic [7:0]    cpu_rdata;
    logic [AW-1:0] vm_addr;
    logic [7:0]    vm_wdata;
    logic          vm_we;
    logic          vm_re;
    logic [7:0]    vm_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int oob     = 0;
    int fill_log[$];
    int ack_q[$];
    logic [7:0] mem [0:153599];

    always #5 clk = ~clk;

    vram_fill_arb dut (
        .clk        (clk),
        .rst        (rst),
        .fill_req   (fill_req),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_w     (fill_w),
        .fill_h     (fill_h),
        .fill_color (fill_color),
        .fill_ack   (fill_ack),
        .fill_busy  (fill_busy),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_rdata  (cpu_rdata),
        .vm_addr    (vm_addr),
        .vm_wdata   (vm_wdata),
        .vm_we      (vm_we),
        .vm_re      (vm_re),
        .vm_rdata   (vm_rdata)
    );

    assign vm_rdata = (vm_addr < 20'd153600) ? mem[vm_addr] : 8'h00;

    // VRAM model and event recorder; cyc is the index of the cycle
    // that ends at this edge
    always @(posedge clk) begin
        if (cyc == 0)
            for (int i = 0; i < 153600; i++) mem[i] = 8'h55;
        if (vm_we) begin
            if (vm_addr < 20'd153600) mem[vm_addr] = vm_wdata;
            else oob++;
            if (!cpu_we) fill_log.push_back(int'(vm_addr));
        end
        if (fill_ack) ack_q.push_back(cyc);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                   tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int log_at(input int lb, input int i);
        if (lb + i < fill_log.size()) return fill_log[lb + i];
        return -1;
    endfunction

    function automatic int ack_at(input int i);
        if (i < ack_q.size()) return ack_q[i];
        return -1;
    endfunction

    function automatic int seq_breaks(input int lb);
        int bad = 0;
        for (int i = lb + 1; i < fill_log.size(); i++)
            if (fill_log[i] != fill_log[i-1] + 1) bad++;
        return bad;
    endfunction

    task automatic do_fill(input int x0, input int y0, input int w,
                           input int h, input logic [7:0] c,
                           output int t0);
        @(posedge clk); #1;
        fill_x0    = XW'(x0);
        fill_y0    = YW'(y0);
        fill_w     = XW'(w);
        fill_h     = YW'(h);
        fill_color = c;
        fill_req   = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        fill_req = 1'b0;
    endtask

    task automatic wait_ack(input int n, input int budget,
                            input string tag);
        int k = 0;
        while (ack_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ack_seen"}, 32'(ack_q.size() >= n), 32'd1);
    endtask

    task automatic run_fill(input int x0, input int y0, input int w,
                            input int h, input logic [7:0] c,
                            input int exp_n, input int exp_lat,
                            input int budget, input string tag,
                            output int lb);
        int t0;
        int ab;
        lb = fill_log.size();
        ab = ack_q.size();
        do_fill(x0, y0, w, h, c, t0);
        wait_ack(ab + 1, budget, tag);
        repeat (2) @(negedge clk);
        check({tag, "_acks"}, ack_q.size() - ab, 1);
        check({tag, "_lat"}, ack_at(ab) - t0, exp_lat);
        check({tag, "_nwr"}, fill_log.size() - lb, exp_n);
        check({tag, "_busy"}, 32'(fill_busy), 32'd0);
    endtask

    initial begin
        int lb;
        int ab;
        int t0;
        int k;
        int rect_exp[6];
        rect_exp = '{1290, 1291, 1292, 1930, 1931, 1932};

        rst = 1'b0;
        fill_req = 1'b0;
        fill_x0 = '0;
        fill_y0 = '0;
        fill_w = '0;
        fill_h = '0;
        fill_color = '0;
        cpu_addr = '0;
        cpu_wdata = '0;
        cpu_we = 1'b0;
        cpu_re = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(fill_busy), 32'd0);
        check("rst_ack", 32'(fill_ack), 32'd0);
        check("rst_we", 32'(vm_we), 32'd0);
        check("rst_re", 32'(vm_re), 32'd0);
        check("rst_addr", 32'(vm_addr), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // small rectangle
        run_fill(10, 2, 3, 2, 8'hAB, 6, 8, 50, "rect", lb);
        for (int i = 0; i < 6; i++)
            check($sformatf("rect_a%0d", i), log_at(lb, i), rect_exp[i]);
        check("rect_left", 32'(mem[1289]), 32'h55);
        check("rect_right", 32'(mem[1293]), 32'h55);
        check("rect_data", 32'(mem[1931]), 32'hAB);

        // clipping at bottom-right corner, then degenerate commands
        run_fill(638, 239, 5, 5, 8'hE1, 2, 4, 50, "corner", lb);
        check("corner_a0", log_at(lb, 0), 153598);
        check("corner_a1", log_at(lb, 1), 153599);
        check("corner_data", 32'(mem[153599]), 32'hE1);
        run_fill(640, 0, 4, 4, 8'h12, 0, 2, 50, "x640", lb);
        run_fill(0, 240, 4, 4, 8'h12, 0, 2, 50, "y240", lb);
        run_fill(0, 0, 4, 0, 8'h12, 0, 2, 50, "h0", lb);

        // full-width fill of the last 40 rows, clipped on both axes
        run_fill(0, 200, 1023, 255, 8'h00, 25600, 25602, 30000,
                 "big", lb);
        check("big_first", log_at(lb, 0), 128000);
        check("big_last", log_at(lb, 25599), 153599);
        check("big_seq", seq_breaks(lb), 0);
        check("big_below", 32'(mem[127999]), 32'h55);
        check("big_d0", 32'(mem[128000]), 32'h00);
        check("big_dend", 32'(mem[153599]), 32'h00);
        check("oob", oob, 0);

        // CPU priority: writes every 3rd cycle plus one read
        lb = fill_log.size();
        ab = ack_q.size();
        do_fill(100, 10, 100, 1, 8'h3C, t0);
        for (int o = 1; o <= 70; o++) begin
            cpu_we = 1'b0;
            cpu_re = 1'b0;
            if (o >= 2 && o <= 59 && (o - 2) % 3 == 0) begin
                cpu_we = 1'b1;
                cpu_addr = ((o - 2) / 3 == 1) ? 20'd6599
                         : 20'(50000 + (o - 2) / 3);
                cpu_wdata = 8'(8'hC0 + (o - 2) / 3);
            end
            if (o == 62) begin
                cpu_re = 1'b1;
                cpu_addr = 20'd50000;
            end
            @(negedge clk);
            if (o == 62) begin
                check("cpu_rdata", 32'(cpu_rdata), 32'hC0);
                check("cpu_vm_re", 32'(vm_re), 32'd1);
                check("cpu_vm_we", 32'(vm_we), 32'd0);
                check("cpu_vm_addr", 32'(vm_addr), 32'd50000);
            end
            @(posedge clk); #1;
        end
        cpu_we = 1'b0;
        cpu_re = 1'b0;
        wait_ack(ab + 1, 200, "cpu");
        repeat (2) @(negedge clk);
        check("cpu_lat", ack_at(ab) - t0, 123);
        check("cpu_nwr", fill_log.size() - lb, 100);
        check("cpu_first", log_at(lb, 0), 6500);
        check("cpu_seq", seq_breaks(lb), 0);
        check("cpu_over", 32'(mem[6599]), 32'h3C);
        check("cpu_w0", 32'(mem[50000]), 32'hC0);
        check("cpu_w2", 32'(mem[50002]), 32'hC2);
        check("cpu_w19", 32'(mem[50019]), 32'hD3);

        // reset in the middle of a fill
        lb = fill_log.size();
        ab = ack_q.size();
        do_fill(0, 50, 200, 1, 8'h77, t0);
        k = 0;
        while (fill_log.size() - lb < 50 && k < 100) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(fill_busy), 32'd0);
        check("mid_we", 32'(vm_we), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_nwr", fill_log.size() - lb, 51);
        check("mid_noack", ack_q.size() - ab, 0);
        run_fill(0, 100, 2, 2, 8'h99, 4, 6, 50, "after", lb);
        check("after_a0", log_at(lb, 0), 64000);
        check("after_a2", log_at(lb, 2), 64640);
        check("after_a3", log_at(lb, 3), 64641);

        // back-to-back: request held one cycle past the first ack
        lb = fill_log.size();
        ab = ack_q.size();
        @(posedge clk); #1;
        fill_x0 = 10'd20;
        fill_y0 = 8'd20;
        fill_w = 10'd2;
        fill_h = 8'd1;
        fill_color = 8'h11;
        fill_req = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        fill_x0 = 10'd30;
        fill_w = 10'd1;
        fill_color = 8'h22;
        wait_ack(ab + 1, 50, "b2b1");
        @(posedge clk); #1;
        @(posedge clk); #1;
        fill_req = 1'b0;
        wait_ack(ab + 2, 50, "b2b2");
        repeat (3) @(negedge clk);
        check("b2b_acks", ack_q.size() - ab, 2);
        check("b2b_lat1", ack_at(ab) - t0, 4);
        check("b2b_lat2", ack_at(ab + 1) - t0, 8);
        check("b2b_nwr", fill_log.size() - lb, 3);
        check("b2b_a1", log_at(lb, 1), 12821);
        check("b2b_a2", log_at(lb, 2), 12830);
        check("b2b_d1", 32'(mem[12821]), 32'h11);
        check("b2b_d2", 32'(mem[12830]), 32'h22);
        check("b2b_busy", 32'(fill_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
